// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Optional input glitch filter is enabled with `define PWM_CAP_FILTER_EN.
package pwm_pkg;

    localparam int DEFAULT_N = 9;
    localparam int CNT_W     = DEFAULT_N + 1;
    localparam logic [CNT_W-1:0] TIMEOUT = '1;

    typedef enum logic {
        IDLE,
        MEAS
    } cap_state_t;

    // Largest value an (n+1)-bit measurement counter reaches before timing out
    function automatic int timeout_for(input int n);
        return (1 << (n + 1)) - 1;
    endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning: synchronizer, optional glitch filter (PWM_CAP_FILTER_EN)
// and rising-edge detect for the captured PWM waveform.
module pwm_in_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] run_cnt;
    logic          filt;

    // Output follows the synchronized input only after FILT_LEN agreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
            filt    <= 1'b0;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == FW'(FILT_LEN - 1)) begin
            run_cnt <= '0;
            filt    <= sync[SYNC_STAGES-1];
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign s = filt;
`else
    assign s = sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles.
// Define PWM_CAP_FILTER_EN to insert a FILT_LEN-cycle glitch filter on the input.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [N:0] high_out,
    output logic [N:0] period_out,
    output logic       valid,
    output logic       stuck,
    output logic       level
);

    localparam int W = N + 1;
    localparam logic [W-1:0] TMO = W'(timeout_for(N));
    localparam logic [W-1:0] ONE = W'(1);

    logic s;
    logic rise;

    cap_state_t state, state_nx;
    logic [W-1:0] period_cnt, period_cnt_nx;
    logic [W-1:0] high_cnt, high_cnt_nx;
    logic [W-1:0] high_out_nx, period_out_nx;
    logic         valid_nx, stuck_nx;

    pwm_in_cond #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_cond (
        .clk   (clk),
        .reset (reset),
        .pwm_in(pwm_in),
        .s     (s),
        .rise  (rise)
    );

    assign level = s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            high_out   <= '0;
            period_out <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state      <= state_nx;
            period_cnt <= period_cnt_nx;
            high_cnt   <= high_cnt_nx;
            high_out   <= high_out_nx;
            period_out <= period_out_nx;
            valid      <= valid_nx;
            stuck      <= stuck_nx;
        end
    end

    // The rise cycle itself counts as the first high cycle of the new period
    always_comb begin
        state_nx      = state;
        period_cnt_nx = period_cnt;
        high_cnt_nx   = high_cnt;
        high_out_nx   = high_out;
        period_out_nx = period_out;
        valid_nx      = 1'b0;
        stuck_nx      = stuck;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx      = MEAS;
                    period_cnt_nx = ONE;
                    high_cnt_nx   = ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    high_out_nx   = high_cnt;
                    period_out_nx = period_cnt;
                    valid_nx      = 1'b1;
                    stuck_nx      = 1'b0;
                    period_cnt_nx = ONE;
                    high_cnt_nx   = ONE;
                end else if (period_cnt == TMO) begin
                    stuck_nx      = 1'b1;
                    state_nx      = IDLE;
                    period_cnt_nx = '0;
                    high_cnt_nx   = '0;
                end else begin
                    period_cnt_nx = period_cnt + ONE;
                    high_cnt_nx   = high_cnt + {{(W-1){1'b0}}, s};
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (N=9): duty/period measurement,
// stuck detection, async reset and glitch handling with or without the filter.
module tb_pwm_capture;

`ifdef PWM_CAP_FILTER_EN
    localparam int HI_D       = 507;
    localparam int LO_D       = 5;
    localparam int GL_VALIDS  = 16;
    localparam int GL_HIGH    = 300;
    localparam int GL_PERIOD  = 512;
`else
    localparam int HI_D       = 511;
    localparam int LO_D       = 1;
    localparam int GL_VALIDS  = 22;
    localparam int GL_HIGH    = 96;
    localparam int GL_PERIOD  = 308;
`endif

    logic       clk;
    logic       reset;
    logic       pwm_in;
    logic [9:0] high_out;
    logic [9:0] period_out;
    logic       valid;
    logic       stuck;
    logic       level;

    int tests = 0;
    int fails = 0;

    int   cyc        = 0;
    int   valid_cnt  = 0;
    int   valid_cyc  = 0;
    int   stuck_cyc  = 0;
    logic stuck_prev = 1'b0;
    logic [9:0] cap_high   = '0;
    logic [9:0] cap_period = '0;

    pwm_capture dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .high_out  (high_out),
        .period_out(period_out),
        .valid     (valid),
        .stuck     (stuck),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every valid pulse and the cycle at which stuck rises
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) begin
            valid_cnt  = valid_cnt + 1;
            cap_high   = high_out;
            cap_period = period_out;
            valid_cyc  = cyc;
        end
        if (stuck && !stuck_prev) stuck_cyc = cyc;
        stuck_prev = stuck;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic drive_periods(input int h, input int p, input int k);
        for (int i = 0; i < k; i++) begin
            hold(1'b1, h);
            hold(1'b0, p - h);
        end
    endtask

    task automatic glitch_period();
        hold(1'b1, 100);
        hold(1'b0, 2);
        hold(1'b1, 100);
        hold(1'b0, 2);
        hold(1'b1, 96);
        hold(1'b0, 212);
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_output("rst_high_out",   32'(high_out),   0);
        check_output("rst_period_out", 32'(period_out), 0);
        check_output("rst_valid",      32'(valid),      0);
        check_output("rst_stuck",      32'(stuck),      0);
        check_output("rst_level",      32'(level),      0);
        @(negedge clk);
        reset = 1'b0;

        // 128/512 loopback: four rises give three complete periods
        drive_periods(128, 512, 4);
        #1;
        check_output("d128_valids", valid_cnt, 3);
        check_output("d128_high",   32'(cap_high),   128);
        check_output("d128_period", 32'(cap_period), 512);
        check_output("d128_stuck",  32'(stuck),      0);

        drive_periods(HI_D, 512, 2);
        #1;
        check_output("dhi_high",   32'(cap_high),   HI_D);
        check_output("dhi_period", 32'(cap_period), 512);

        drive_periods(LO_D, 512, 2);
        #1;
        check_output("dlo_high",   32'(cap_high),   LO_D);
        check_output("dlo_period", 32'(cap_period), 512);

        // Stuck low: timeout 1023 cycles after the last valid
        hold(1'b0, 1100);
        #1;
        check_output("low_stuck",  32'(stuck), 1);
        check_output("low_delay",  stuck_cyc - valid_cyc, 1023);
        check_output("low_valids", valid_cnt, 7);
        check_output("low_level",  32'(level), 0);
        check_output("low_hold",   32'(high_out), LO_D);

        drive_periods(128, 512, 1);
        #1;
        check_output("resume1_stuck",  32'(stuck), 1);
        check_output("resume1_valids", valid_cnt, 7);
        drive_periods(128, 512, 2);
        #1;
        check_output("resume_stuck",  32'(stuck), 0);
        check_output("resume_valids", valid_cnt, 9);
        check_output("resume_high",   32'(cap_high),   128);
        check_output("resume_period", 32'(cap_period), 512);

        // Stuck high: the initial rise closes the last 128/512 period
        hold(1'b1, 1100);
        #1;
        check_output("high_valids", valid_cnt, 10);
        check_output("high_stuck",  32'(stuck), 1);
        check_output("high_delay",  stuck_cyc - valid_cyc, 1023);
        check_output("high_level",  32'(level), 1);
        check_output("high_hold_h", 32'(high_out),   128);
        check_output("high_hold_p", 32'(period_out), 512);

        // Async reset roughly 50 cycles into a high phase
        hold(1'b0, 10);
        hold(1'b1, 50);
        @(negedge clk);
        reset  = 1'b1;
        pwm_in = 1'b0;
        #1;
        check_output("arst_high_out",   32'(high_out),   0);
        check_output("arst_period_out", 32'(period_out), 0);
        check_output("arst_stuck",      32'(stuck),      0);
        check_output("arst_valid",      32'(valid),      0);
        check_output("arst_level",      32'(level),      0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 10);
        drive_periods(200, 400, 1);
        #1;
        check_output("post_rst1_valids", valid_cnt, 10);
        drive_periods(200, 400, 2);
        #1;
        check_output("post_rst_valids", valid_cnt, 12);
        check_output("post_rst_high",   32'(cap_high),   200);
        check_output("post_rst_period", 32'(cap_period), 400);
        check_output("post_rst_stuck",  32'(stuck),      0);

        // 2-cycle low glitches inside a 300-cycle high phase
        glitch_period();
        glitch_period();
        glitch_period();
        hold(1'b1, 10);
        #1;
        check_output("glitch_valids", valid_cnt, GL_VALIDS);
        check_output("glitch_high",   32'(cap_high),   GL_HIGH);
        check_output("glitch_period", 32'(cap_period), GL_PERIOD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
